// File: rtl/if_id_buffer.sv
// IF/ID two-entry skid buffer: captures {pc, instr} fetch pairs, precomputes
// pc+4 and the misaligned-fetch flag, and hands them to decode over a
// valid/ready handshake. in_ready doubles as the PC stall signal.
module if_id_buffer #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        out_adel,
    output logic [1:0]  count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        adel;
    } entry_t;

    entry_t      head;
    entry_t      tail;
    entry_t      new_entry;
    logic [1:0]  count_q;
    logic        push;
    logic        pop;

    // Handshake and head presentation, all derived from registered state
    always_comb begin
        new_entry.pc    = pc_in;
        new_entry.instr = instr_in;
        new_entry.pc4   = pc_in + 32'd4;
        new_entry.adel  = |pc_in[1:0];

        in_ready  = (count_q != 2'd2) & ~flush;
        out_valid = (count_q != 2'd0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;

        // Head slot is never cleared on the last pop or a flush, so out_pc
        // and out_pc4 naturally hold their previous values while empty.
        out_pc    = head.pc;
        out_pc4   = head.pc4;
        out_instr = out_valid ? head.instr : NOP_INSTR;
        out_adel  = out_valid & head.adel;
        count     = count_q;
    end

    // FIFO storage and occupancy; flush overrides any push/pop
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            count_q    <= 2'd0;
            head.pc    <= PC_RESET;
            head.instr <= NOP_INSTR;
            head.pc4   <= PC_RESET + 32'd4;
            head.adel  <= 1'b0;
            tail       <= '0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head <= new_entry;
                    end else begin
                        tail <= new_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head <= tail;
                    end
                    count_q <= count_q - 2'd1;
                end
                // push requires count!=2 and pop requires count!=0, so the
                // simultaneous case only happens at count 1: replace the head.
                2'b11: begin
                    head <= new_entry;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed fetch vectors feed a reference queue;
// a negedge monitor compares the DUT head and status against that queue.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_adel;
    logic [1:0]  count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        adel;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_pc;
    logic [31:0] last_pc4;

    if_id_buffer #(
        .PC_RESET (32'h0000_3000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .pc_in    (pc_in),
        .instr_in (instr_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .out_pc4  (out_pc4),
        .out_adel (out_adel),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected pairs are enqueued when a push is issued
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sb.delete();
            last_pc  = 32'h0000_3000;
            last_pc4 = 32'h0000_3004;
        end else begin
            automatic bit do_push = in_valid && (sb.size() < 2) && !flush;
            automatic bit do_pop  = (sb.size() != 0) && out_ready;
            if (sb.size() != 0) begin
                last_pc  = sb[0].pc;
                last_pc4 = sb[0].pc4;
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (do_pop) begin
                    last_pc  = sb[0].pc;
                    last_pc4 = sb[0].pc4;
                    void'(sb.pop_front());
                end
                if (do_push) begin
                    exp_t e;
                    e.pc    = pc_in;
                    e.instr = instr_in;
                    e.pc4   = pc_in + 32'd4;
                    e.adel  = (pc_in[1:0] != 2'b00);
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor: mid-cycle comparison of the presented head against the model
    always @(negedge clk) begin
        chk("count", {30'd0, count}, sb.size());
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() != 2) && !flush});
        if (sb.size() != 0) begin
            chk("head_pc", out_pc, sb[0].pc);
            chk("head_instr", out_instr, sb[0].instr);
            chk("head_pc4", out_pc4, sb[0].pc4);
            chk("head_adel", {31'd0, out_adel}, {31'd0, sb[0].adel});
        end else begin
            chk("empty_instr", out_instr, 32'h0);
            chk("empty_adel", {31'd0, out_adel}, 32'h0);
            chk("empty_pc", out_pc, last_pc);
            chk("empty_pc4", out_pc4, last_pc4);
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic ordy);
        #1;
        in_valid  = v;
        pc_in     = pc;
        instr_in  = ins;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        Reset = 1'b0;
        in_valid = 1'b0; pc_in = '0; instr_in = '0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // 1: reset with random fetch traffic
        repeat (3) step($urandom_range(0, 1), $urandom, $urandom, 1'b0, $urandom_range(0, 1));
        chk("rst_pc", out_pc, 32'h0000_3000);
        chk("rst_pc4", out_pc4, 32'h0000_3004);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #1 Reset = 1'b1;

        // 2: streaming at one pair per cycle
        step(1'b1, 32'h0000_3000, 32'h1111_0001, 1'b0, 1'b1);
        chk("stream_pc0", out_pc, 32'h0000_3000);
        chk("stream_pc4_0", out_pc4, 32'h0000_3004);
        step(1'b1, 32'h0000_3004, 32'h1111_0002, 1'b0, 1'b1);
        step(1'b1, 32'h0000_3008, 32'h1111_0003, 1'b0, 1'b1);
        chk("stream_pc2", out_pc, 32'h0000_3008);
        chk("stream_count", {30'd0, count}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("stream_hold_pc", out_pc, 32'h0000_3008);

        // 3: decode stall fills the buffer, third pair held off
        step(1'b1, 32'h0000_3000, 32'h2222_0001, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3004, 32'h2222_0002, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3008, 32'h2222_0003, 1'b0, 1'b0);
        chk("full_count", {30'd0, count}, 32'd2);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head", out_pc, 32'h0000_3000);
        step(1'b1, 32'h0000_3008, 32'h2222_0003, 1'b0, 1'b1);
        chk("drain_head", out_pc, 32'h0000_3004);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // 4: flush at count 2 with a simultaneous push
        step(1'b1, 32'h0000_3100, 32'h3333_0001, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3104, 32'h3333_0002, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEE0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_instr", out_instr, 32'h0);
        chk("flush_pc", out_pc, 32'h0000_3100);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // 5: pc+4 wraparound and misaligned fetch flag
        step(1'b1, 32'hFFFF_FFFC, 32'h4444_0001, 1'b0, 1'b1);
        chk("wrap_pc4", out_pc4, 32'h0000_0000);
        step(1'b1, 32'h0000_3002, 32'h4444_0002, 1'b0, 1'b1);
        chk("adel_set", {31'd0, out_adel}, 32'd1);
        step(1'b1, 32'h0000_3010, 32'h4444_0003, 1'b0, 1'b1);
        chk("adel_clear", {31'd0, out_adel}, 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // 6: asynchronous reset between edges with the buffer full
        step(1'b1, 32'h0000_4000, 32'h5555_0001, 1'b0, 1'b0);
        step(1'b1, 32'h0000_4004, 32'h5555_0002, 1'b0, 1'b0);
        chk("pre_rst_count", {30'd0, count}, 32'd2);
        #1 Reset = 1'b0;
        #1;
        chk("async_count", {30'd0, count}, 32'd0);
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_pc", out_pc, 32'h0000_3000);
        chk("async_pc4", out_pc4, 32'h0000_3004);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #1 Reset = 1'b1;
        step(1'b1, 32'h0000_5000, 32'h6666_0001, 1'b0, 1'b1);
        chk("post_rst_pc", out_pc, 32'h0000_5000);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
